// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the 32-bit <-> 16-bit SRAM controller.
//   state_t  : controller FSM states (IDLE, LO, HI, DONE)
//   MEM_BASE : byte address at which the SRAM window starts
//   SRAM_AW  : SRAM half-word address width
//   SRAM_DW  : SRAM data bus width
//   WORD_W   : pipeline word width
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] MEM_BASE = 32'd1024;
  localparam int          SRAM_AW  = 18;
  localparam int          SRAM_DW  = 16;
  localparam int          WORD_W   = 32;

  // Size of the SRAM window in bytes: 2^(SRAM_AW) half-words * 2 bytes.
  localparam logic [31:0] MEM_SPAN = 32'h0008_0000;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit MEM-stage load/store into two 16-bit
// accesses on an asynchronous external SRAM (low half first, then high half).
//
// Parameters:
//   WAIT_CYCLES  cycles each half-word phase is held on the SRAM bus (1..7)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   wr_en/rd_en  store / load request (write wins when both are high)
//   address      byte address, SRAM window starts at MEM_BASE
//   write_data   store data
//   read_data    registered load data, valid while ready=1 in DONE
//   ready        handshake back to the pipeline (freeze = ~ready)
//   addr_err     bad-address flag in the DONE cycle (only with the check built in)
//   SRAM_*       external SRAM bus; OE/CE/UB/LB permanently enabled
//   state_dbg    current FSM state, for observation
//
// Handshake: a request is a level on rd_en/wr_en sampled in IDLE. The
// controller accepts it in that cycle and holds ready low until the word
// transfer finishes; ready is high for exactly one DONE cycle, which is the
// cycle in which the pipeline may consume read_data and move on. Inputs are
// ignored outside IDLE, so the latched transaction always completes.
//
// Build option: define SRAM_ADDR_CHECK_EN to reject addresses outside the
// SRAM window or not word aligned (IDLE -> DONE with addr_err=1, no SRAM
// cycle). Without it addresses are simply truncated onto the SRAM.
module sram_controller
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [1:0]  state_dbg
);

  localparam logic [2:0] PHASE_LAST = 3'(WAIT_CYCLES - 1);

  state_t      state;
  logic [2:0]  phase_cnt;
  logic        op_wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic        dq_oe;
  logic [15:0] dq_out;

  // Half-word pair index of the requested word inside the SRAM window.
  logic [31:0] addr_off;
  logic [16:0] word_in;
  logic        req;
  logic        unused_addr_bits;

  assign addr_off         = address - MEM_BASE;
  assign word_in          = addr_off[18:2];
  assign req              = rd_en | wr_en;
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
  logic req_bad;
  logic addr_err_q;

  assign req_bad  = (address < MEM_BASE) ||
                    (address >= (MEM_BASE + MEM_SPAN)) ||
                    (address[1:0] != 2'b00);
  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

  // Only in IDLE does ready look at the request inputs; a request arriving
  // in IDLE freezes the pipeline in that same cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE: ready = ~req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      phase_cnt <= 3'd0;
      op_wr_q   <= 1'b0;
      word_q    <= 17'd0;
      wdata_q   <= 32'd0;
      read_data <= 32'd0;
      SRAM_ADDR <= 18'd0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= 16'd0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          phase_cnt <= 3'd0;
          if (req) begin
            op_wr_q <= wr_en;
            word_q  <= word_in;
            wdata_q <= write_data;
`ifdef SRAM_ADDR_CHECK_EN
            if (req_bad) begin
              // Rejected: finish without touching the SRAM bus.
              state      <= ST_DONE;
              addr_err_q <= 1'b1;
            end else begin
              state     <= ST_LO;
              SRAM_ADDR <= {word_in, 1'b0};
              SRAM_WE_N <= ~wr_en;
              dq_oe     <= wr_en;
              dq_out    <= write_data[15:0];
            end
`else
            state     <= ST_LO;
            SRAM_ADDR <= {word_in, 1'b0};
            SRAM_WE_N <= ~wr_en;
            dq_oe     <= wr_en;
            dq_out    <= write_data[15:0];
`endif
          end
        end

        ST_LO: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= 3'd0;
            state     <= ST_HI;
            // WE_N stays low across the half boundary; the SRAM latches on
            // the address/data change while the write strobe is held.
            SRAM_ADDR <= {word_q, 1'b1};
            dq_out    <= wdata_q[31:16];
            if (!op_wr_q) begin
              read_data[15:0] <= SRAM_DQ;
            end
          end else begin
            phase_cnt <= phase_cnt + 3'd1;
          end
        end

        ST_HI: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= 3'd0;
            state     <= ST_DONE;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!op_wr_q) begin
              read_data[31:16] <= SRAM_DQ;
            end
          end else begin
            phase_cnt <= phase_cnt + 3'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
`ifdef SRAM_ADDR_CHECK_EN
          addr_err_q <= 1'b0;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign state_dbg = state;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller. Two instances share
// clock and reset: u1 with WAIT_CYCLES=1 (vector table, reset abort, optional
// address check) and u3 with WAIT_CYCLES=3 (phase-length sequence). Each has a
// small half-word SRAM model indexed by SRAM_ADDR[9:0].
module tb_sram_controller;

  localparam int W1 = 1;
  localparam int W3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance u1 (W=1) ----------------
  logic        wr1 = 1'b0, rd1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] read_data1;
  logic        ready1, addr_err1;
  wire  [15:0] dq1;
  logic [17:0] sram_addr1;
  logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;
  logic [1:0]  state1;

  sram_controller #(.WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
    .address(addr1), .write_data(wdata1),
    .read_data(read_data1), .ready(ready1), .addr_err(addr_err1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1),
    .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1),
    .state_dbg(state1)
  );

  logic [15:0] mem1 [1024] = '{default: 16'h0000};
  assign dq1 = we_n1 ? mem1[sram_addr1[9:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n1) mem1[sram_addr1[9:0]] <= dq1;

  // ---------------- instance u3 (W=3) ----------------
  logic        wr3 = 1'b0, rd3 = 1'b0;
  logic [31:0] addr3 = '0, wdata3 = '0;
  logic [31:0] read_data3;
  logic        ready3, addr_err3;
  wire  [15:0] dq3;
  logic [17:0] sram_addr3;
  logic        we_n3, oe_n3, ce_n3, ub_n3, lb_n3;
  logic [1:0]  state3;

  sram_controller #(.WAIT_CYCLES(W3)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3),
    .address(addr3), .write_data(wdata3),
    .read_data(read_data3), .ready(ready3), .addr_err(addr_err3),
    .SRAM_DQ(dq3), .SRAM_ADDR(sram_addr3), .SRAM_WE_N(we_n3),
    .SRAM_OE_N(oe_n3), .SRAM_CE_N(ce_n3), .SRAM_UB_N(ub_n3), .SRAM_LB_N(lb_n3),
    .state_dbg(state3)
  );

  logic [15:0] mem3 [1024] = '{default: 16'h0000};
  assign dq3 = we_n3 ? mem3[sram_addr3[9:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n3) mem3[sram_addr3[9:0]] <= dq3;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] sa;      // expected SRAM_ADDR during LO
    logic [31:0] exp_rd;  // expected read_data in DONE
  } vec_t;

  vec_t vecs [11];

  // One full transaction on u1: request held for a single cycle, then the
  // inputs are scrambled to show the latched transaction is what completes.
  task automatic run_txn(input vec_t v);
    logic [9:0] idx;
    idx = v.sa[9:0];
    @(posedge clk); #1;
    wr1 = v.wr; rd1 = v.rd; addr1 = v.addr; wdata1 = v.wdata;
    @(negedge clk);
    check("req_ready_low", {31'd0, ready1}, 32'd0);
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'hFFFF_FFF3; wdata1 = 32'h5555_AAAA;
    for (int k = 1; k <= 2 * W1; k++) begin
      @(negedge clk);
      check("busy_ready", {31'd0, ready1}, 32'd0);
      check("sram_addr", {14'd0, sram_addr1}, (k <= W1) ? {14'd0, v.sa} : {14'd0, v.sa | 18'd1});
      check("we_n", {31'd0, we_n1}, {31'd0, ~v.wr});
      if (!v.wr) check("dq_not_driven", {16'd0, dq1}, {16'd0, mem1[sram_addr1[9:0]]});
    end
    @(negedge clk);
    check("done_ready", {31'd0, ready1}, 32'd1);
    check("done_read_data", read_data1, v.exp_rd);
    check("done_we_n", {31'd0, we_n1}, 32'd1);
    if (v.wr) begin
      check("mem_lo", {16'd0, mem1[idx]}, {16'd0, v.wdata[15:0]});
      check("mem_hi", {16'd0, mem1[idx + 10'd1]}, {16'd0, v.wdata[31:16]});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd1024,     32'hDEADBEEF, 18'd0,       32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 32'd1024,     32'h0,        18'd0,       32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'd1028,     32'h12345678, 18'd2,       32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'd1028,     32'h0,        18'd2,       32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 32'd1424,     32'hA5A55A5A, 18'd200,     32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 32'd1024,     32'h0,        18'd0,       32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'd1424,     32'h0,        18'd200,     32'hA5A55A5A};
    vecs[7]  = '{1'b1, 1'b0, 32'h0008_03FC, 32'hCAFEF00D, 18'h3FFFE,  32'hA5A55A5A};
    vecs[8]  = '{1'b0, 1'b1, 32'h0008_03FC, 32'h0,        18'h3FFFE,  32'hCAFEF00D};
    vecs[9]  = '{1'b1, 1'b1, 32'd1032,     32'h0BADF00D, 18'd4,       32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b1, 32'd1032,     32'h0,        18'd4,       32'h0BADF00D};

    // Reset values, checked while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_read_data", read_data1, 32'd0);
    check("rst_we_n", {31'd0, we_n1}, 32'd1);
    check("rst_sram_addr", {14'd0, sram_addr1}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err1}, 32'd0);
    check("rst_state", {30'd0, state1}, 32'd0);
    check("rst_ready_w3", {31'd0, ready3}, 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, ready1}, 32'd1);

    // Table: back-to-back transactions on u1.
    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

`ifdef SRAM_ADDR_CHECK_EN
    // Misaligned read: rejected in one cycle, no SRAM activity.
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = 32'd1026;
    @(negedge clk);
    check("chk_req_ready", {31'd0, ready1}, 32'd0);
    @(posedge clk); #1;
    rd1 = 1'b0;
    @(negedge clk);
    check("chk_done_ready", {31'd0, ready1}, 32'd1);
    check("chk_addr_err", {31'd0, addr_err1}, 32'd1);
    check("chk_state", {30'd0, state1}, 32'd3);
    check("chk_we_n", {31'd0, we_n1}, 32'd1);
    check("chk_read_data", read_data1, 32'h0BADF00D);
    @(negedge clk);
    check("chk_err_clear", {31'd0, addr_err1}, 32'd0);
    check("chk_idle", {30'd0, state1}, 32'd0);
    // Out-of-window write: WE_N never asserted.
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 32'd1024 + 32'h0008_0000; wdata1 = 32'h1;
    @(negedge clk);
    check("chk_oow_we_n0", {31'd0, we_n1}, 32'd1);
    @(posedge clk); #1;
    wr1 = 1'b0;
    @(negedge clk);
    check("chk_oow_err", {31'd0, addr_err1}, 32'd1);
    check("chk_oow_we_n1", {31'd0, we_n1}, 32'd1);
`endif

    // Reset pulse during HI of a write.
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 32'd1036; wdata1 = 32'h1111_2222;
    @(posedge clk); #1;
    wr1 = 1'b0;
    @(negedge clk);
    check("abort_lo_we_n", {31'd0, we_n1}, 32'd0);
    @(negedge clk);
    check("abort_hi_addr", {14'd0, sram_addr1}, 32'd7);
    check("abort_hi_we_n", {31'd0, we_n1}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_state", {30'd0, state1}, 32'd0);
    check("abort_we_n", {31'd0, we_n1}, 32'd1);
    check("abort_ready", {31'd0, ready1}, 32'd1);
    check("abort_read_data", read_data1, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_partial_lo", {16'd0, mem1[6]}, 32'h0000_2222);
    check("abort_idle_ready", {31'd0, ready1}, 32'd1);
    check("abort_idle_we_n", {31'd0, we_n1}, 32'd1);

    // W=3: write then read through u3, phase length 3 cycles per half.
    @(posedge clk); #1;
    wr3 = 1'b1; addr3 = 32'd1044; wdata3 = 32'h5678_9ABC;
    @(posedge clk); #1;
    wr3 = 1'b0;
    for (int k = 1; k <= 2 * W3; k++) begin
      @(negedge clk);
      check("w3_wr_we_n", {31'd0, we_n3}, 32'd0);
    end
    @(negedge clk);
    check("w3_wr_done", {31'd0, ready3}, 32'd1);
    check("w3_mem_lo", {16'd0, mem3[10]}, 32'h0000_9ABC);
    check("w3_mem_hi", {16'd0, mem3[11]}, 32'h0000_5678);

    exp_q.push_back(32'h5678_9ABC);
    @(posedge clk); #1;
    rd3 = 1'b1; addr3 = 32'd1044;
    @(negedge clk);
    check("w3_req_ready", {31'd0, ready3}, 32'd0);
    @(posedge clk); #1;
    rd3 = 1'b0;
    for (int k = 1; k <= 2 * W3; k++) begin
      @(negedge clk);
      check("w3_busy_ready", {31'd0, ready3}, 32'd0);
      check("w3_sram_addr", {14'd0, sram_addr3}, (k <= W3) ? 32'd10 : 32'd11);
    end
    @(negedge clk);
    check("w3_done_ready", {31'd0, ready3}, 32'd1);
    check("w3_read_data", read_data3, exp_q.pop_front());
    @(negedge clk);
    check("w3_after_done", {30'd0, state3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the 32-bit MEM stage of the pipeline and a 16-bit asynchronous external SRAM. It splits each 32-bit load/store into two half-word accesses, drives the SRAM bus, and deasserts `ready` until the word transfer is complete. The pipeline derives its global `Freeze` from `~ready`, so all stage registers, including the MEM/WB register, hold while an access is in flight. `read_data` feeds the MEM/WB register's memory-data input directly.

## Interface
- `WAIT_CYCLES`, default 1: cycles each half-word phase is held on the SRAM bus, range 1..7.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (`rst`=0 resets).
- `wr_en` input 1: store request from MEM stage.
- `rd_en` input 1: load request from MEM stage.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data.
- `read_data` output 32: registered load data, valid while `ready`=1 in DONE.
- `ready` output 1: 1 when no access is pending or an access is completing.
- `addr_err` output 1: bad-address flag, see Configuration.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: half-word address.
- `SRAM_WE_N` output 1: active-low write enable.
- `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each: tied 0 (always enabled, full half-word).

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `ready` = ~(rd_en | wr_en), combinational.
  - On a request, latch `address`, `write_data` and op (write wins if both enables are high), then go to LO.
- Address mapping:
  - word = (address − 1024) >> 2, keep bits [16:0].
  - LO drives `SRAM_ADDR` = {word, 1'b0}; HI drives {word, 1'b1}.
- Write:
  - LO drives `write_data[15:0]` on `SRAM_DQ`; HI drives `write_data[31:16]`.
  - `SRAM_WE_N`=0 throughout both phases. Outside write phases `SRAM_DQ` is high-Z and `SRAM_WE_N`=1.
- Read:
  - `SRAM_DQ` is high-Z.
  - Capture `SRAM_DQ` into `read_data[15:0]` on the last LO cycle and into `read_data[31:16]` on the last HI cycle.
- Phase timing: each of LO and HI lasts `WAIT_CYCLES` cycles, counted by a 3-bit phase counter.
- DONE: `ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Requests deasserted or changed mid-access are ignored; the latched transaction always completes.
- Back-to-back: a new request seen in IDLE the cycle after DONE starts a fresh access. No request is lost or merged.
- `read_data` holds its last value until the next read captures new data; writes leave it unchanged.

## Timing
- Reset values: state IDLE, `read_data`=0, phase counter 0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0, `addr_err`=0.
- `ready` is 1 out of reset whenever no request is present.
- Request first seen in IDLE at cycle 0 → `ready`=1 at cycle 1+2·WAIT_CYCLES. With W=1 that is cycle 3, giving 3 freeze cycles.
- Reset asserted mid-access: the access aborts immediately, `SRAM_WE_N`→1, the bus is released, and a partial write may remain in SRAM.
- `ready` depends combinationally on `rd_en`/`wr_en` in IDLE only. In all other states it is decoded from the state register.

## Configuration
- `SRAM_ADDR_CHECK_EN`, defined:
  - A request with address < 1024, address ≥ 1024+2^19, or address[1:0]≠0 skips LO/HI and goes IDLE→DONE.
  - No SRAM cycle is issued and `SRAM_WE_N` stays 1.
  - `addr_err`=1 during that DONE cycle; `read_data` is unchanged.
- Undefined: no check is made, `addr_err` is tied 0, and the address is truncated per the mapping.

## Structure
- Package `sram_pkg`: state enum, `MEM_BASE`=1024, `SRAM_AW`=18, `SRAM_DW`=16, `WORD_W`=32.
- No sub-module. The tristate driver is a single continuous assign inside this module.

## Test plan
- Write 0xDEADBEEF to 1024, W=1 → `ready` low for cycles 0–2; SRAM model half-word 0 = 0xBEEF, 1 = 0xDEAD; `ready`=1 at cycle 3.
- Read 1024 after the write → `read_data`=0xDEADBEEF in DONE; `SRAM_DQ` never driven by the DUT.
- Back-to-back write 0x12345678 to 1028, then read 1028 → second access starts the cycle after DONE; halves at SRAM addresses 2/3; read returns 0x12345678.
- W=3, read → DONE exactly 7 cycles after the request; `SRAM_ADDR` stable 3 cycles per half.
- Reset pulse during HI of a write → next cycle IDLE, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `ready`=1 with no request.
- With `SRAM_ADDR_CHECK_EN`, read address 1026 → DONE at cycle 1, `addr_err`=1, no SRAM activity.
